// File: rtl/mips_pkg.sv
// Shared pipeline types: register-index width, the hard-wired zero register and
// the per-stage hazard slot record tracked by the scoreboard.
package mips_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             rw;
        logic             load;
    } hazard_slot_t;

    localparam hazard_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
// One-cycle update latency; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall unit: load-use and data-memory-wait detection over EX/MEM slots.
// Control outputs are combinational; slots and counters update on the next edge.
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ID_valid_i,
    input  logic [REG_W-1:0] ID_Rs_i,
    input  logic [REG_W-1:0] ID_Rt_i,
    input  logic             ID_use_rs_i,
    input  logic             ID_use_rt_i,
    input  logic [REG_W-1:0] ID_Rd_i,
    input  logic             ID_rw_i,
    input  logic             ID_memread_i,
    input  logic             flush_i,
    input  logic             MEM_ready_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IDEX_bubble_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o
);

    hazard_slot_t ex_q, mem_q;
    hazard_slot_t ex_d, mem_d;

    logic live;
    logic ex_load_hazard;
    logic rs_hit, rt_hit;
    logic lu, freeze;
    logic lu_inc, mem_inc;

    assign live           = ID_valid_i & ~flush_i;
    assign ex_load_hazard = ex_q.v & ex_q.load & ex_q.rw & (ex_q.rd != REG_ZERO);
    assign rs_hit         = ID_use_rs_i & (ID_Rs_i == ex_q.rd);
    assign rt_hit         = ID_use_rt_i & (ID_Rt_i == ex_q.rd);
    assign lu             = live & ex_load_hazard & (rs_hit | rt_hit);
    assign freeze         = ~MEM_ready_i & mem_q.v;

    always_comb begin
        ex_d          = ex_q;
        mem_d         = mem_q;
        PC_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IDEX_bubble_o = ~live;
        pipe_freeze_o = 1'b0;

        if (!rst_n_i) begin
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
        end else if (freeze) begin
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b0;
            pipe_freeze_o = 1'b1;
        end else if (lu) begin
            // The load moves on to MEM, where forwarding covers the next cycle.
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
            mem_d         = ex_q;
            ex_d          = SLOT_EMPTY;
        end else begin
            mem_d      = ex_q;
            ex_d.v     = live;
            ex_d.rd    = ID_Rd_i;
            ex_d.rw    = ID_rw_i & live;
            ex_d.load  = ID_memread_i & live;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    assign lu_inc  = rst_n_i & lu & ~freeze;
    assign mem_inc = rst_n_i & freeze;

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk_i),
        .clr_n (rst_n_i),
        .inc   (lu_inc),
        .count (lu_stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_mem_cnt (
        .clk   (clk_i),
        .clr_n (rst_n_i),
        .inc   (mem_inc),
        .count (mem_stall_cnt_o)
    );

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Tracks in-flight destination registers of the EX and MEM pipeline stages and decides when the ID stage must stall. It covers the two cases that operand forwarding cannot resolve: a load-use dependence on the instruction in EX, and a data-memory wait in MEM. It sits beside the ID/EX pipeline register and drives the PC, IF/ID write enables and the ID/EX bubble mux. It also keeps saturating stall counters for performance reporting.

## Interface
- `CNT_W`, 16: width of each stall counter.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset, synchronous and active-low.
- `ID_valid_i`  in  1  IF/ID holds a live instruction.
- `ID_Rs_i`  in  5  source register rs of the ID instruction.
- `ID_Rt_i`  in  5  source register rt of the ID instruction.
- `ID_use_rs_i`  in  1  ID instruction reads rs.
- `ID_use_rt_i`  in  1  ID instruction reads rt.
- `ID_Rd_i`  in  5  final destination of the ID instruction (rt/rd already muxed).
- `ID_rw_i`  in  1  ID instruction writes the register file.
- `ID_memread_i`  in  1  ID instruction is a load.
- `flush_i`  in  1  taken branch/jump kills the ID instruction this cycle.
- `MEM_ready_i`  in  1  data memory completes this cycle; 0 means hold the pipeline.
- `PC_write_o`  out  1  PC may update.
- `IFID_write_o`  out  1  IF/ID may update.
- `IDEX_bubble_o`  out  1  load a NOP into ID/EX.
- `pipe_freeze_o`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `lu_stall_cnt_o`  out  CNT_W  load-use stall cycles, saturating.
- `mem_stall_cnt_o`  out  CNT_W  memory-wait cycles, saturating.

## Operation
- State is two slots, EX and MEM. Each slot holds {v, rd[4:0], rw, load}.
- `live = ID_valid_i & ~flush_i`.
- `lu` is asserted when all of the following hold:
  - `live`;
  - EX.v & EX.load & EX.rw & EX.rd≠0;
  - (ID_use_rs_i & ID_Rs_i==EX.rd) | (ID_use_rt_i & ID_Rt_i==EX.rd).
- `freeze = ~MEM_ready_i & MEM.v`. An empty MEM slot never freezes.
- Priority: freeze over lu over normal flow.
- Freeze:
  - PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=0, pipe_freeze_o=1.
  - Slots hold their values.
  - mem_stall_cnt increments.
- lu (no freeze):
  - PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1.
  - MEM←EX; EX←{v=0}.
  - lu_stall_cnt increments.
- Normal:
  - Write enables are 1.
  - IDEX_bubble_o = ~live.
  - MEM←EX; EX←{live, ID_Rd_i, ID_rw_i & live, ID_memread_i & live}.
- flush_i with a would-be lu: the ID instruction is dead, so no stall. Output is bubble=1 with write enables 1.
- Counters saturate at all-ones and never wrap.
- Register $0 never causes a stall.

## Timing
- Control outputs are combinational from the slots and the current inputs. There is no registered latency on stall decisions.
- Slot and counter updates take effect on the next rising edge.
- A load-use dependence costs exactly one stall cycle. In the next cycle the load sits in MEM and forwarding covers it.
- A freeze lasts while MEM_ready_i=0. It releases in the cycle MEM_ready_i=1, and normal or lu evaluation resumes in that same cycle.
- Reset:
  - While rst_n_i=0, outputs are forced to PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, pipe_freeze_o=0.
  - At the edge, slots clear to v=0 and counters clear to 0.
  - Reset in the middle of a freeze or lu aborts it; no state survives.
- First cycle after reset: no stall possible (slots empty).

## Structure
- Shared package `mips_pkg`:
  - typedef `hazard_slot_t` {v, rd, rw, load};
  - constant `REG_ZERO` = 5'd0;
  - constant `REG_W` = 5.
- One sub-module, `sat_counter`, parameterised by width, with inputs inc and synchronous active-low clear. It is instantiated twice.
- The slot pipeline and the decision logic are inline.

## Test plan
- **Load-use:** issue `lw $5`, then `add $6,$5,$1`.
  - Expected: one cycle with PC_write_o=0, IDEX_bubble_o=1.
  - Expected: lu_stall_cnt_o=1.
  - Expected: the add issues on the following cycle with no further stall.
- **No stall for a non-load or $0:** `add $5` followed by a use of $5; then `lw $0` followed by a use of $0.
  - Expected: PC_write_o stays 1 throughout.
  - Expected: IDEX_bubble_o=0 throughout.
- **Memory wait:** hold MEM_ready_i=0 for 3 cycles with MEM occupied.
  - Expected: pipe_freeze_o=1 for 3 cycles.
  - Expected: slots unchanged.
  - Expected: mem_stall_cnt_o=3.
- **Freeze priority:** an lu condition and a freeze in the same cycle.
  - Expected: freeze outputs, IDEX_bubble_o=0, lu_stall_cnt unchanged.
  - Expected: lu is taken on the first cycle after release.
- **Flush during lu:** flush_i=1 while a dependent instruction sits in ID.
  - Expected: PC_write_o=1, IDEX_bubble_o=1, no counter increment.
- **Reset and saturation:**
  - Assert rst_n_i=0 during a freeze. Expected: slots clear and counters clear to 0.
  - With CNT_W=4, freeze for 20 cycles. Expected: mem_stall_cnt_o stops at 15.
